// File: rtl/uc_mc_if.sv
// Control-unit bus: the instruction/cache-status inputs from the datapath side
// and the registered decode controls going back to the datapath and caches.
// master = datapath/caches side, slave = control unit.
interface uc_mc_if #(
    parameter int INSTR_W = 32
);
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               iCacheMiss;
    logic               dCacheMiss;

    logic [1:0]         MuxB;
    logic               MuxD;
    logic               MuxAddrB;
    logic               RF_wrd;
    logic [1:0]         DC_rd_wr;
    logic               DC_we;
    logic               IC_we;
    logic [1:0]         MuxPc;
    logic               stall;
    logic               illegal;

    modport master (
        output instr, instr_valid, iCacheMiss, dCacheMiss,
        input  MuxB, MuxD, MuxAddrB, RF_wrd, DC_rd_wr, DC_we, IC_we,
               MuxPc, stall, illegal
    );

    modport slave (
        input  instr, instr_valid, iCacheMiss, dCacheMiss,
        output MuxB, MuxD, MuxAddrB, RF_wrd, DC_rd_wr, DC_we, IC_we,
               MuxPc, stall, illegal
    );
endinterface

// File: rtl/uc_mc.sv
// uc_mc: stall-aware processor control unit.
// Decodes the 7-bit opcode into registered datapath selects and write strobes,
// and sequences multi-cycle MUL plus instruction/data cache-miss stalls.
// Optional build macro UC_TRAP_EN: when defined, an unknown opcode locks the
// unit in a TRAP state (stall and illegal held) until reset; otherwise the
// opcode gives a one-cycle illegal pulse and executes as a NOP.
module uc_mc #(
    parameter int INSTR_W = 32,
    parameter int OPC_LSB = 25,
    parameter int MUL_LAT = 4
) (
    input  logic   clk,
    input  logic   reset,
    uc_mc_if.slave bus
);

    localparam logic [6:0] OP_ADD = 7'b0000000;
    localparam logic [6:0] OP_SUB = 7'b0000001;
    localparam logic [6:0] OP_MUL = 7'b0000010;
    localparam logic [6:0] OP_LDB = 7'b0010000;
    localparam logic [6:0] OP_LDW = 7'b0010001;
    localparam logic [6:0] OP_STB = 7'b0010010;
    localparam logic [6:0] OP_STW = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b0110000;
    localparam logic [6:0] OP_JMP = 7'b0110001;

    // Counter is loaded with the remaining MUL cycles after the decode cycle.
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

`ifdef UC_TRAP_EN
    typedef enum logic [2:0] {RUN, MUL_WAIT, DMISS, IMISS, TRAP} state_t;
`else
    typedef enum logic [1:0] {RUN, MUL_WAIT, DMISS, IMISS} state_t;
`endif

    state_t     state_reg;
    logic [3:0] cnt_reg;

    logic [1:0] mux_b_reg;
    logic       mux_d_reg;
    logic       mux_addr_b_reg;
    logic       rf_wrd_reg;
    logic [1:0] dc_rd_wr_reg;
    logic       dc_we_reg;
    logic       ic_we_reg;
    logic [1:0] mux_pc_reg;
    logic       stall_reg;
    logic       illegal_reg;

    logic [6:0] opc;
    logic       is_ldst;
    logic       unused_instr_bits;

    assign opc     = bus.instr[OPC_LSB+6:OPC_LSB];
    // LDB/LDW/STB/STW share opcode prefix 00100; bit 1 separates store from load.
    assign is_ldst = bus.instr_valid && (opc[6:2] == 5'b00100);
    // Non-opcode instruction fields belong to the datapath, not to this unit.
    assign unused_instr_bits = ^bus.instr;

    // Control FSM: state, MUL counter and every registered output in one block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RUN;
            cnt_reg        <= 4'd0;
            mux_b_reg      <= 2'b00;
            mux_d_reg      <= 1'b0;
            mux_addr_b_reg <= 1'b0;
            rf_wrd_reg     <= 1'b0;
            dc_rd_wr_reg   <= 2'b00;
            dc_we_reg      <= 1'b0;
            ic_we_reg      <= 1'b0;
            mux_pc_reg     <= 2'b00;
            stall_reg      <= 1'b0;
            illegal_reg    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state explicitly re-asserts them.
            rf_wrd_reg  <= 1'b0;
            dc_we_reg   <= 1'b0;
            ic_we_reg   <= 1'b0;
            illegal_reg <= 1'b0;

            case (state_reg)
                RUN: begin
                    mux_b_reg      <= 2'b00;
                    mux_d_reg      <= 1'b0;
                    mux_addr_b_reg <= 1'b0;
                    dc_rd_wr_reg   <= 2'b00;
                    stall_reg      <= 1'b0;
                    mux_pc_reg     <= 2'b00;

                    if (is_ldst && bus.dCacheMiss) begin
                        // Selects for the pending access are set now and held
                        // through the miss; mux_d_reg later says load vs store.
                        state_reg      <= DMISS;
                        mux_b_reg      <= 2'b01;
                        mux_d_reg      <= ~opc[1];
                        mux_addr_b_reg <= opc[1];
                        dc_rd_wr_reg   <= opc[1:0];
                        stall_reg      <= 1'b1;
                        mux_pc_reg     <= 2'b11;
                    end else if (bus.iCacheMiss) begin
                        state_reg  <= IMISS;
                        stall_reg  <= 1'b1;
                        mux_pc_reg <= 2'b11;
                    end else if (!bus.instr_valid) begin
                        mux_pc_reg <= 2'b11;
                    end else begin
                        case (opc)
                            OP_ADD, OP_SUB: rf_wrd_reg <= 1'b1;
                            OP_MUL: begin
                                if (MUL_LAT == 1) begin
                                    rf_wrd_reg <= 1'b1;
                                end else begin
                                    state_reg  <= MUL_WAIT;
                                    cnt_reg    <= MUL_CNT_INIT;
                                    stall_reg  <= 1'b1;
                                    mux_pc_reg <= 2'b11;
                                end
                            end
                            OP_LDB, OP_LDW: begin
                                mux_b_reg    <= 2'b01;
                                mux_d_reg    <= 1'b1;
                                dc_rd_wr_reg <= opc[1:0];
                                rf_wrd_reg   <= 1'b1;
                            end
                            OP_STB, OP_STW: begin
                                mux_b_reg      <= 2'b01;
                                mux_addr_b_reg <= 1'b1;
                                dc_rd_wr_reg   <= opc[1:0];
                                dc_we_reg      <= 1'b1;
                            end
                            OP_BEQ: mux_pc_reg <= 2'b01;
                            OP_JMP: begin
                                mux_pc_reg <= 2'b10;
                                mux_b_reg  <= 2'b10;
                            end
                            default: begin
                                illegal_reg <= 1'b1;
`ifdef UC_TRAP_EN
                                state_reg   <= TRAP;
                                stall_reg   <= 1'b1;
                                mux_pc_reg  <= 2'b11;
`endif
                            end
                        endcase
                    end
                end

                MUL_WAIT: begin
                    // Cache misses are deliberately not looked at here.
                    if (cnt_reg == 4'd1) begin
                        cnt_reg    <= 4'd0;
                        rf_wrd_reg <= 1'b1;
                        stall_reg  <= 1'b0;
                        mux_pc_reg <= 2'b00;
                        state_reg  <= RUN;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end

                DMISS: begin
                    if (!bus.dCacheMiss) begin
                        rf_wrd_reg <= mux_d_reg;
                        dc_we_reg  <= ~mux_d_reg;
                        stall_reg  <= 1'b0;
                        mux_pc_reg <= 2'b00;
                        state_reg  <= bus.iCacheMiss ? IMISS : RUN;
                    end
                end

                IMISS: begin
                    mux_b_reg      <= 2'b00;
                    mux_d_reg      <= 1'b0;
                    mux_addr_b_reg <= 1'b0;
                    dc_rd_wr_reg   <= 2'b00;
                    stall_reg      <= 1'b1;
                    mux_pc_reg     <= 2'b11;
                    // Fill write happens while still stalled; RUN resumes after.
                    if (!bus.iCacheMiss) begin
                        ic_we_reg <= 1'b1;
                        state_reg <= RUN;
                    end
                end

`ifdef UC_TRAP_EN
                TRAP: begin
                    illegal_reg <= 1'b1;
                    stall_reg   <= 1'b1;
                    mux_pc_reg  <= 2'b11;
                end
`endif

                default: state_reg <= RUN;
            endcase
        end
    end

    assign bus.MuxB     = mux_b_reg;
    assign bus.MuxD     = mux_d_reg;
    assign bus.MuxAddrB = mux_addr_b_reg;
    assign bus.RF_wrd   = rf_wrd_reg;
    assign bus.DC_rd_wr = dc_rd_wr_reg;
    assign bus.DC_we    = dc_we_reg;
    assign bus.IC_we    = ic_we_reg;
    assign bus.MuxPc    = mux_pc_reg;
    assign bus.stall    = stall_reg;
    assign bus.illegal  = illegal_reg;

endmodule

// File: tb/tb_uc_mc.sv
// Bench for uc_mc: two instances (MUL_LAT=4 and MUL_LAT=1) share one stimulus
// stream; a behavioural model predicts every output cycle, and directed
// sequences pin the model with hand-computed literal expectations.
module tb_uc_mc;

    typedef struct packed {
        logic [1:0] muxb;
        logic       muxd;
        logic       muxaddrb;
        logic       rf_wrd;
        logic [1:0] dc_rd_wr;
        logic       dc_we;
        logic       ic_we;
        logic [1:0] muxpc;
        logic       stall;
        logic       illegal;
    } ctl_t;

    localparam logic [6:0] ADD = 7'h00, SUB = 7'h01, MUL = 7'h02;
    localparam logic [6:0] LDB = 7'h10, LDW = 7'h11, STB = 7'h12, STW = 7'h13;
    localparam logic [6:0] BEQ = 7'h30, JMP = 7'h31, BAD = 7'h7F;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        valid, im, dm;

    int checks   = 0;
    int failures = 0;
    bit armed    = 0;

    uc_mc_if #(.INSTR_W(32)) if4();
    uc_mc_if #(.INSTR_W(32)) if1();

    assign if4.instr = instr;  assign if4.instr_valid = valid;
    assign if4.iCacheMiss = im; assign if4.dCacheMiss = dm;
    assign if1.instr = instr;  assign if1.instr_valid = valid;
    assign if1.iCacheMiss = im; assign if1.dCacheMiss = dm;

    uc_mc #(.INSTR_W(32), .OPC_LSB(25), .MUL_LAT(4)) u_dut4 (.clk(clk), .reset(rst), .bus(if4));
    uc_mc #(.INSTR_W(32), .OPC_LSB(25), .MUL_LAT(1)) u_dut1 (.clk(clk), .reset(rst), .bus(if1));

    ctl_t act4, act1;
    assign act4 = {if4.MuxB, if4.MuxD, if4.MuxAddrB, if4.RF_wrd, if4.DC_rd_wr,
                   if4.DC_we, if4.IC_we, if4.MuxPc, if4.stall, if4.illegal};
    assign act1 = {if1.MuxB, if1.MuxD, if1.MuxAddrB, if1.RF_wrd, if1.DC_rd_wr,
                   if1.DC_we, if1.IC_we, if1.MuxPc, if1.stall, if1.illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input ctl_t act, input ctl_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h (muxb,muxd,addrb,rf,rw,dcwe,icwe,pc,stall,ill)",
                     name, $time, act, exp);
        end
    endtask

    function automatic ctl_t mk(logic [1:0] muxb, logic muxd, logic addrb, logic rf,
                                logic [1:0] rw, logic we, logic icwe, logic [1:0] pc,
                                logic st, logic ill);
        mk = {muxb, muxd, addrb, rf, rw, we, icwe, pc, st, ill};
    endfunction

    // ---------------- behavioural model ----------------
    ctl_t       exp_q [2];
    int         mul_left [2];
    bit         in_d [2], d_load [2], in_i [2], in_t [2];
    logic [1:0] d_sz [2];

    task automatic model_step(input int k);
        ctl_t       c;
        logic [6:0] o;
        int         lat;
        bit         is_ld, is_st;
        lat   = (k == 0) ? 4 : 1;
        c     = '0;
        o     = instr[31:25];
        is_ld = valid && (o[6:1] == 6'b001000);
        is_st = valid && (o[6:1] == 6'b001001);
        if (rst) begin
            mul_left[k] = 0; in_d[k] = 0; in_i[k] = 0; in_t[k] = 0;
        end else if (in_t[k]) begin
            c.muxpc = 2'd3; c.stall = 1'b1; c.illegal = 1'b1;
        end else if (mul_left[k] > 0) begin
            mul_left[k]--;
            if (mul_left[k] == 0) c.rf_wrd = 1'b1;
            else begin c.stall = 1'b1; c.muxpc = 2'd3; end
        end else if (in_d[k]) begin
            c.muxb = 2'd1; c.muxd = d_load[k]; c.muxaddrb = !d_load[k]; c.dc_rd_wr = d_sz[k];
            if (dm) begin
                c.stall = 1'b1; c.muxpc = 2'd3;
            end else begin
                c.rf_wrd = d_load[k]; c.dc_we = !d_load[k];
                in_d[k] = 0; in_i[k] = im;
            end
        end else if (in_i[k]) begin
            c.stall = 1'b1; c.muxpc = 2'd3;
            if (!im) begin c.ic_we = 1'b1; in_i[k] = 0; end
        end else if ((is_ld || is_st) && dm) begin
            in_d[k] = 1; d_load[k] = is_ld; d_sz[k] = o[1:0];
            c.muxb = 2'd1; c.muxd = is_ld; c.muxaddrb = is_st; c.dc_rd_wr = o[1:0];
            c.stall = 1'b1; c.muxpc = 2'd3;
        end else if (im) begin
            in_i[k] = 1; c.stall = 1'b1; c.muxpc = 2'd3;
        end else if (!valid) begin
            c.muxpc = 2'd3;
        end else if (o == ADD || o == SUB) begin
            c.rf_wrd = 1'b1;
        end else if (o == MUL) begin
            if (lat == 1) c.rf_wrd = 1'b1;
            else begin mul_left[k] = lat - 1; c.stall = 1'b1; c.muxpc = 2'd3; end
        end else if (is_ld) begin
            c.muxb = 2'd1; c.muxd = 1'b1; c.dc_rd_wr = o[1:0]; c.rf_wrd = 1'b1;
        end else if (is_st) begin
            c.muxb = 2'd1; c.muxaddrb = 1'b1; c.dc_rd_wr = o[1:0]; c.dc_we = 1'b1;
        end else if (o == BEQ) begin
            c.muxpc = 2'd1;
        end else if (o == JMP) begin
            c.muxpc = 2'd2; c.muxb = 2'd2;
        end else begin
            c.illegal = 1'b1;
`ifdef UC_TRAP_EN
            in_t[k] = 1; c.stall = 1'b1; c.muxpc = 2'd3;
`endif
        end
        exp_q[k] = c;
    endtask

    // Advance the model on every edge and compare both instances 1 time unit later.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        if (rst) armed = 1;
        #1;
        if (armed) begin
            chk("model_lat4", act4, exp_q[0]);
            chk("model_lat1", act1, exp_q[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic [6:0] opc, input logic v, input logic i_m,
                        input logic d_m, input logic r);
        @(negedge clk);
        instr        = $urandom;
        instr[31:25] = opc;
        valid = v; im = i_m; dm = d_m; rst = r;
        @(posedge clk);
        #2;
    endtask

    logic [6:0] tbl [0:9];

    initial begin
        rst = 1'b1; instr = '0; valid = 1'b0; im = 1'b0; dm = 1'b0;
        tbl[0] = ADD; tbl[1] = SUB; tbl[2] = MUL; tbl[3] = LDB; tbl[4] = LDW;
        tbl[5] = STB; tbl[6] = STW; tbl[7] = BEQ; tbl[8] = JMP; tbl[9] = BAD;

        // Reset state
        tick(ADD, 0, 0, 0, 1);
        tick(ADD, 1, 1, 1, 1);
        chk("reset_lat4", act4, '0);
        chk("reset_lat1", act1, '0);

        // ADD, then idle
        tick(ADD, 1, 0, 0, 0);
        chk("add", act4, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tick(ADD, 0, 0, 0, 0);
        chk("idle", act4, mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0));

        // MUL: three stall cycles then RF write (lat 4); immediate write (lat 1)
        tick(MUL, 1, 0, 0, 0);
        chk("mul4_c1", act4, mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0));
        chk("mul1_c1", act1, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tick(MUL, 1, 1, 1, 0);
        chk("mul4_c2", act4, mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0));
        tick(MUL, 1, 0, 0, 0);
        chk("mul4_c3", act4, mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0));
        tick(MUL, 1, 0, 0, 0);
        chk("mul4_c4", act4, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tick(ADD, 0, 0, 0, 0);
        chk("mul4_done", act4, mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0));

        // LDW with a five-cycle data miss
        for (int i = 0; i < 5; i++) tick(LDW, 1, 0, 1, 0);
        chk("ldw_miss", act4, mk(1, 1, 0, 0, 1, 0, 0, 3, 1, 0));
        tick(LDW, 1, 0, 0, 0);
        chk("ldw_fill", act4, mk(1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        tick(ADD, 0, 0, 0, 0);

        // STB with both misses: data first, then instruction
        for (int i = 0; i < 3; i++) tick(STB, 1, 1, 1, 0);
        chk("stb_miss", act4, mk(1, 0, 1, 0, 2, 0, 0, 3, 1, 0));
        tick(STB, 1, 1, 0, 0);
        chk("stb_we", act4, mk(1, 0, 1, 0, 2, 1, 0, 0, 0, 0));
        tick(ADD, 0, 1, 0, 0);
        tick(ADD, 0, 1, 0, 0);
        chk("imiss_hold", act4, mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 0));
        tick(ADD, 0, 0, 0, 0);
        chk("ic_we", act4, mk(0, 0, 0, 0, 0, 0, 1, 3, 1, 0));
        tick(ADD, 0, 0, 0, 0);
        chk("imiss_done", act4, mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0));

        // Unknown opcode
        tick(BAD, 1, 0, 0, 0);
`ifdef UC_TRAP_EN
        chk("illegal", act4, mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 1));
        tick(ADD, 1, 0, 0, 0);
        chk("trap_hold", act4, mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 1));
`else
        chk("illegal", act4, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tick(ADD, 0, 0, 0, 0);
        chk("illegal_end", act4, mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
`endif
        tick(ADD, 0, 0, 0, 1);
        chk("reset_again", act4, '0);

        // Branch and jump
        tick(BEQ, 1, 0, 0, 0);
        chk("beq", act4, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tick(JMP, 1, 0, 0, 0);
        chk("jmp", act4, mk(2, 0, 0, 0, 0, 0, 0, 2, 0, 0));

        // Reset on cycle 2 of MUL_WAIT, then a normal ADD
        tick(MUL, 1, 0, 0, 0);
        tick(MUL, 1, 0, 0, 0);
        tick(MUL, 1, 0, 0, 1);
        chk("mul_reset", act4, '0);
        tick(ADD, 1, 0, 0, 0);
        chk("add_after_reset", act4, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        // Randomised traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            logic [6:0] o;
            o = ($urandom % 5 == 0) ? 7'($urandom) : tbl[$urandom % 10];
            tick(o, ($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
                 ($urandom % 64) == 0);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uc_mc.md
Name: uc_mc

Overview:
- Parametrised, stall-aware successor to the basic processor control unit.
- Decodes the 7-bit opcode at instr[OPC_LSB+6:OPC_LSB] into datapath mux selects and write strobes.
- A state machine sequences multi-cycle MUL and instruction/data cache-miss stalls.
- Sits between the instruction register and the datapath/caches; all outputs are registered.

Parameters:
- INSTR_W, 32: instruction width.
- OPC_LSB, 25: bit position of opcode LSB; opcode is 7 bits wide.
- MUL_LAT, 4: cycles a MUL occupies before RF write; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- instr  input  INSTR_W  current instruction; held stable by datapath while stall=1
- instr_valid  input  1  instr is a real instruction this cycle
- iCacheMiss  input  1  instruction cache miss, level, held until fill ready
- dCacheMiss  input  1  data cache miss, level, held until fill ready
- MuxB  output  2  00 regB, 01 sext imm, 10 jump offset
- MuxD  output  1  1 = writeback from data cache
- MuxAddrB  output  1  1 = regB address from store field
- RF_wrd  output  1  register file write strobe, one cycle
- DC_rd_wr  output  2  access size/type = opcode[1:0] for LD/ST
- DC_we  output  1  data cache write strobe, one cycle
- IC_we  output  1  instruction cache fill write strobe, one cycle
- MuxPc  output  2  00 pc+4, 01 branch, 10 jump, 11 hold PC
- stall  output  1  pipeline freeze; PC and instr held
- illegal  output  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset: state=RUN, counter=0; all outputs 0.
- Latency: decode is registered; controls for instr sampled at edge N are visible after edge N.
- States: RUN, MUL_WAIT, DMISS, IMISS.
- In RUN with instr_valid=0: strobes 0, MuxPc=11, stall=0.
- Priority in RUN: dCacheMiss on an LD/ST > iCacheMiss > normal decode.
- RUN decode, no miss:
  - ADD 0000000, SUB 0000001: MuxB=00, MuxD=0, MuxAddrB=0, RF_wrd=1, MuxPc=00.
  - MUL 0000010 with MUL_LAT=1: same as ADD.
  - MUL with MUL_LAT>1: go to MUL_WAIT, counter=MUL_LAT-1, stall=1, MuxPc=11, RF_wrd=0.
  - LDB/LDW 001000x: MuxB=01, MuxD=1, DC_rd_wr=opc[1:0], RF_wrd=1.
  - STB/STW 001001x: MuxB=01, MuxAddrB=1, DC_rd_wr=opc[1:0], DC_we=1.
  - BEQ 0110000: MuxPc=01, MuxB=00.
  - JMP 0110001: MuxPc=10, MuxB=10.
  - Other opcodes: illegal=1, all strobes 0, MuxPc=00 (NOP).
- MUL_WAIT: decrement counter each cycle. On counter reaching 1: RF_wrd=1, stall=0, MuxPc=00, return to RUN. Total MUL occupancy = MUL_LAT cycles.
- DMISS: entered when an LD/ST is decoded with dCacheMiss=1.
  - Mux selects and DC_rd_wr held; strobes 0; stall=1; MuxPc=11.
  - First cycle dCacheMiss=0: fire RF_wrd (load) or DC_we (store), stall=0, MuxPc=00.
  - Next state is IMISS if iCacheMiss=1, else RUN.
- IMISS: entered from RUN when iCacheMiss=1 and no dCacheMiss LD/ST.
  - stall=1, MuxPc=11, strobes 0.
  - First cycle iCacheMiss=0: IC_we=1 for one cycle, stall stays 1 that cycle, then RUN.
- Cache misses during MUL_WAIT are ignored until return to RUN.
- Strobes never exceed one cycle per instruction; RF_wrd and DC_we are never both 1.
- Reset mid-operation (any state): next cycle RUN, counter 0, all outputs 0; no strobe fires.

Optional Feature:
- Macro UC_TRAP_EN.
- Defined: an unknown opcode enters state TRAP. TRAP holds stall=1, MuxPc=11, all strobes 0, and illegal stays 1 until reset.
- Undefined: an unknown opcode gives a one-cycle illegal pulse and is executed as a NOP.

Test Plan:
- ADD opcode 0000000, valid, no miss -> next cycle RF_wrd=1, MuxB=00, MuxPc=00, stall=0 for exactly 1 cycle.
- MUL with MUL_LAT=4 -> stall=1 for 3 cycles, RF_wrd=1 on cycle 4 only, then RUN; repeat with MUL_LAT=1 -> RF_wrd next cycle, no stall.
- LDW with dCacheMiss high for 5 cycles -> stall=1, MuxD=1, DC_rd_wr=01 held; RF_wrd=1 one cycle after dCacheMiss drops.
- STB with dCacheMiss and iCacheMiss both high -> DMISS first, DC_we=1 on release, then IMISS; IC_we=1 one cycle after iCacheMiss drops.
- Opcode 1111111 -> illegal pulse, no strobes, MuxPc=00; with UC_TRAP_EN -> stall/illegal held until reset.
- Reset asserted on cycle 2 of MUL_WAIT -> all outputs 0 next cycle, no RF_wrd, subsequent ADD decodes normally.
